// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-way multiplexer.
//   sel_width  : select/tag width for an N-way mux ($clog2(N), at least 1)
//   chan_slice : extracts channel idx of a packed multi-channel bus
package mux_pkg;

  // Upper bounds for chan_slice; N*WIDTH must not exceed MaxBusW and WIDTH must
  // not exceed MaxWordW. Unused upper bits are constant and trimmed away.
  localparam int unsigned MaxBusW  = 4096;
  localparam int unsigned MaxWordW = 256;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Returns channel idx in the low bits; the caller truncates to its word width.
  function automatic logic [MaxWordW-1:0] chan_slice(input logic [MaxBusW-1:0] bus,
                                                     input int unsigned idx,
                                                     input int unsigned width);
    logic [MaxBusW-1:0] shifted;
    shifted = bus >> (idx * width);
    return shifted[MaxWordW-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over N request lines.
//   clk, rst   : clock, asynchronous active-high reset (pointer -> N-1)
//   req        : request per channel
//   advance    : pointer moves to the current grant (a transfer happened)
//   grant_idx  : granted channel index
//   grant_vld  : some request is granted
// The search starts one past the last granted channel and wraps N-1 -> 0.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [SEL_W-1:0] ptr;

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = N; k >= 1; k--) begin
      cand = (32'(ptr) + k) % N;
      if (|(req & (N'(1) << cand))) begin
        grant_vld = 1'b1;
        grant_idx = SEL_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= SEL_W'(N - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N-way, WIDTH-bit multiplexer with valid/ready handshakes.
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : N packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : channel has a word
//   in_ready   : channel word is taken this cycle if its valid is high
//   sel        : channel select
//   out_data   : registered selected word
//   out_valid  : out_data holds an unaccepted word
//   out_ready  : consumer accepts out_data this cycle
//   out_sel    : channel that produced out_data
//   sel_err    : registered pulse, sel >= N while the register was free
// Build option MUX_RR_ARB_EN: the channel is chosen by a round-robin arbiter
// over in_valid instead of sel; sel is ignored and sel_err stays 0.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N = 4,
  localparam int unsigned SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel,
  output logic               sel_err
);

  logic [WIDTH-1:0] chans [N];
  logic [WIDTH-1:0] sel_word;
  logic [SEL_W-1:0] g;
  logic             g_ok;
  logic             free;
  logic             xfer;
  logic             sel_err_d;

  for (genvar i = 0; i < N; i++) begin : g_chan
    assign chans[i] = WIDTH'(chan_slice(MaxBusW'(in_data), i, WIDTH));
  end

  assign free = !out_valid || out_ready;

`ifdef MUX_RR_ARB_EN
  logic unused_sel;
  assign unused_sel = ^sel;

  // Pointer only moves on an actual transfer, so a stall never skips a channel.
  rr_arbiter #(
    .N (N)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (xfer),
    .grant_idx (g),
    .grant_vld (g_ok)
  );

  assign sel_err_d = 1'b0;
`else
  assign g         = sel;
  assign g_ok      = (32'(sel) < N);
  assign sel_err_d = free && !g_ok;
`endif

  always_comb begin
    in_ready = '0;
    if (free && g_ok) begin
      in_ready = N'(1) << g;
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N; i++) begin
      if (g == SEL_W'(i)) begin
        sel_word = chans[i];
      end
    end
  end

  // out_data/out_sel only load on a transfer, so out_ready never reaches them
  // combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      if (xfer) begin
        out_data  <= sel_word;
        out_sel   <= g;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      sel_err <= sel_err_d;
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: the stimulus pushes expected words, a
// monitor pops and compares on every accepted output. A second N=3 instance
// covers the out-of-range select.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] in_data;
  logic [3:0]   in_valid, in_ready;
  logic [1:0]   sel, out_sel;
  logic [31:0]  out_data;
  logic         out_valid, out_ready, sel_err;

  logic [95:0]  in_data3;
  logic [2:0]   in_valid3, in_ready3;
  logic [1:0]   sel3, out_sel3;
  logic [31:0]  out_data3;
  logic         out_valid3, out_ready3, sel_err3;

  mux_n_pipe #(.WIDTH(32), .N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .sel_err   (sel_err)
  );

  mux_n_pipe #(.WIDTH(32), .N(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .sel       (sel3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_sel   (out_sel3),
    .sel_err   (sel_err3)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  sel;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [31:0] w);
    in_data[i*32 +: 32] = w;
  endtask

  // Monitor: every accepted output must match the oldest expected word.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_output: got %0h/%0d, expected none", out_data, out_sel);
      end else begin
        e = q.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_sel", 64'(out_sel), 64'(e.sel));
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_valid = '0;
    sel = '0;
    out_ready = 1'b0;
    in_data3 = '0;
    in_valid3 = '0;
    sel3 = '0;
    out_ready3 = 1'b1;

    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_out_sel", 64'(out_sel), 0);
    check("rst_sel_err", 64'(sel_err), 0);
    tick();
    rst = 1'b0;

`ifdef MUX_RR_ARB_EN
    begin
      logic [1:0] order [6];
      order = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
      for (int i = 0; i < 4; i++) set_ch(i, 32'hC0DE0000 + 32'(i));
      in_valid = 4'b1011;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
        q.push_back('{32'hC0DE0000 + 32'(order[k]), order[k]});
        @(negedge clk);
        check("rr_in_ready", 64'(in_ready), 64'(4'b0001 << order[k]));
        check("rr_sel_err", 64'(sel_err), 0);
        tick();
      end
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("rr_stall_in_ready", 64'(in_ready), 0);
        check("rr_stall_out_sel", 64'(out_sel), 3);
        tick();
      end
      out_ready = 1'b1;
      q.push_back('{32'hC0DE0000, 2'd0});
      @(negedge clk);
      check("rr_resume_in_ready", 64'(in_ready), 64'(4'b0001));
      tick();
      in_valid = '0;
      @(negedge clk);
      check("rr_resume_out_sel", 64'(out_sel), 0);
      tick();
    end
`else
    // Basic select
    sel = 2'd1;
    set_ch(1, 32'h20F00200);
    in_valid = 4'b0010;
    out_ready = 1'b1;
    q.push_back('{32'h20F00200, 2'd1});
    @(negedge clk);
    check("basic_in_ready", 64'(in_ready), 64'(4'b0010));
    tick();
    in_valid = '0;
    @(negedge clk);
    check("basic_out_valid", 64'(out_valid), 1);
    tick();
    @(negedge clk);
    check("drain_out_valid", 64'(out_valid), 0);
    check("drain_hold_data", 64'(out_data), 64'(32'h20F00200));
    check("drain_hold_sel", 64'(out_sel), 1);

    // Back-pressure
    tick();
    out_ready = 1'b0;
    sel = 2'd0;
    set_ch(0, 32'hA0A0A0A0);
    in_valid = 4'b0001;
    q.push_back('{32'hA0A0A0A0, 2'd0});
    @(negedge clk);
    check("bp_load_in_ready", 64'(in_ready), 64'(4'b0001));
    tick();
    for (int c = 0; c < 3; c++) begin
      sel = 2'(c + 1);
      in_data = {4{32'hDEAD0000 + 32'(c)}};
      in_valid = 4'b1111;
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 0);
      check("bp_out_data", 64'(out_data), 64'(32'hA0A0A0A0));
      check("bp_out_valid", 64'(out_valid), 1);
      tick();
    end
    sel = 2'd2;
    set_ch(2, 32'hB0B0B0B0);
    in_valid = 4'b0100;
    out_ready = 1'b1;
    q.push_back('{32'hB0B0B0B0, 2'd2});
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'(4'b0100));
    tick();
    in_valid = '0;
    @(negedge clk);
    check("bp_refill_out_valid", 64'(out_valid), 1);
    tick();

    // Streaming on channel 3
    sel = 2'd3;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_ch(3, 32'(k));
      in_valid = 4'b1000;
      q.push_back('{32'(k), 2'd3});
      @(negedge clk);
      check("stream_in_ready", 64'(in_ready), 64'(4'b1000));
      if (k > 0) check("stream_no_bubble", 64'(out_valid), 1);
      tick();
    end
    in_valid = '0;
    @(negedge clk);
    check("stream_last_valid", 64'(out_valid), 1);
    tick();
    @(negedge clk);
    check("stream_end_valid", 64'(out_valid), 0);

    // Reset mid-stall
    tick();
    sel = 2'd2;
    set_ch(2, 32'h0200F00F);
    in_valid = 4'b0100;
    out_ready = 1'b0;
    tick();
    in_valid = '0;
    @(negedge clk);
    check("stall_out_valid", 64'(out_valid), 1);
    check("stall_out_data", 64'(out_data), 64'(32'h0200F00F));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 0);
    check("async_rst_out_data", 64'(out_data), 0);
    check("async_rst_out_sel", 64'(out_sel), 0);
    tick();
    rst = 1'b0;

    // Bad select on the 3-channel instance
    sel3 = 2'd3;
    in_valid3 = 3'b111;
    @(negedge clk);
    check("badsel_in_ready", 64'(in_ready3), 0);
    check("badsel_err_before", 64'(sel_err3), 0);
    tick();
    @(negedge clk);
    check("badsel_err", 64'(sel_err3), 1);
    check("badsel_out_valid", 64'(out_valid3), 0);
    tick();
    sel3 = 2'd0;
    in_valid3 = '0;
    tick();
    @(negedge clk);
    check("badsel_err_clear", 64'(sel_err3), 0);
    tick();
    sel3 = 2'd2;
    in_data3[64 +: 32] = 32'h33333333;
    in_valid3 = 3'b100;
    @(negedge clk);
    check("n3_in_ready", 64'(in_ready3), 64'(3'b100));
    tick();
    in_valid3 = '0;
    @(negedge clk);
    check("n3_out_valid", 64'(out_valid3), 1);
    check("n3_out_data", 64'(out_data3), 64'(32'h33333333));
    check("n3_out_sel", 64'(out_sel3), 2);
`endif

    repeat (3) tick();
    check("queue_empty", 64'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
